// File: rtl/pipe_pkg.sv
// Shared definitions for valid/ready pipeline stage registers.
// The state encoding doubles as the occupancy count driven on level_o.
package pipe_pkg;

    typedef logic [1:0] level_t;

    localparam level_t ST_EMPTY = 2'd0;
    localparam level_t ST_ONE   = 2'd1;
    localparam level_t ST_FULL  = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer; full throughput with a registered in_ready_o.
// Flush or reset empties the stage and loads RESET_DATA into both entries.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          DATA_W     = 64,
    parameter logic [DATA_W-1:0]    RESET_DATA = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        level_o
);

    level_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept;
    logic              pop;

    assign accept      = in_valid_i & in_ready_q;
    assign pop         = out_valid_o & out_ready_i;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_ready_o  = in_ready_q;
    assign out_data_o  = main_q;
    assign level_o     = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // Flush wins over any same-cycle accept; the incoming beat is dropped.
            state_d = ST_EMPTY;
            main_d  = RESET_DATA;
            skid_d  = RESET_DATA;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_data_i;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign in_ready_d = (state_d != ST_FULL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= RESET_DATA;
            skid_q     <= RESET_DATA;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed vector table plus randomised FIFO scoreboard for pipe_stage_skid_reg.
// A non-zero RESET_DATA is used so the bubble value is distinguishable from real payloads.
module tb_pipe_stage_skid_reg;

    localparam int unsigned DATA_W = 64;
    localparam logic [DATA_W-1:0] RD = 64'hDEAD_BEEF_0BAD_F00D;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        level;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid_reg #(
        .DATA_W     (DATA_W),
        .RESET_DATA (RD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .level_o     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_lv;
        logic [63:0] e_d;
    } vec_t;

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    vec_t vecs[29];
    logic [63:0] q[$];

    initial begin
        // rst flush iv data ordy | out_valid in_ready level out_data (after the edge)
        vecs[0]  = '{1, 0, 1, 64'h77, 0, 0, 1, 0, RD};     // reset held with input valid
        vecs[1]  = '{1, 0, 1, 64'h77, 0, 0, 1, 0, RD};
        vecs[2]  = '{0, 0, 0, 64'h0,  0, 0, 1, 0, RD};     // one cycle after release
        vecs[3]  = '{0, 0, 1, 64'h1,  1, 1, 1, 1, 64'h1};  // streaming
        vecs[4]  = '{0, 0, 1, 64'h2,  1, 1, 1, 1, 64'h2};
        vecs[5]  = '{0, 0, 1, 64'h3,  1, 1, 1, 1, 64'h3};
        vecs[6]  = '{0, 0, 0, 64'h0,  1, 0, 1, 0, 64'h3};  // drain; main keeps old value
        vecs[7]  = '{0, 0, 1, 64'hA,  0, 1, 1, 1, 64'hA};  // backpressure
        vecs[8]  = '{0, 0, 1, 64'hB,  0, 1, 0, 2, 64'hA};
        vecs[9]  = '{0, 0, 1, 64'hC,  0, 1, 0, 2, 64'hA};  // C refused
        vecs[10] = '{0, 0, 1, 64'hC,  1, 1, 1, 1, 64'hB};  // pop A, C still refused
        vecs[11] = '{0, 0, 1, 64'hC,  0, 1, 0, 2, 64'hB};  // C accepted into skid
        vecs[12] = '{0, 0, 0, 64'h0,  1, 1, 1, 1, 64'hC};
        vecs[13] = '{0, 0, 0, 64'h0,  1, 0, 1, 0, 64'hC};
        vecs[14] = '{0, 0, 1, 64'hA,  0, 1, 1, 1, 64'hA};  // fill, then flush while FULL
        vecs[15] = '{0, 0, 1, 64'hB,  0, 1, 0, 2, 64'hA};
        vecs[16] = '{0, 1, 1, 64'hD,  0, 0, 1, 0, RD};
        vecs[17] = '{0, 0, 0, 64'h0,  0, 0, 1, 0, RD};     // D never appears
        vecs[18] = '{0, 1, 1, 64'h9,  0, 0, 1, 0, RD};     // held flush discards accepts
        vecs[19] = '{0, 1, 1, 64'h9,  0, 0, 1, 0, RD};
        vecs[20] = '{0, 0, 1, 64'h4,  1, 1, 1, 1, 64'h4};
        vecs[21] = '{0, 1, 1, 64'h6,  1, 0, 1, 0, RD};     // flush beats accept + pop
        vecs[22] = '{0, 0, 1, 64'h7,  1, 1, 1, 1, 64'h7};
        vecs[23] = '{1, 1, 1, 64'h8,  1, 0, 1, 0, RD};     // reset + flush mid-stream
        vecs[24] = '{0, 0, 1, 64'h5,  1, 1, 1, 1, 64'h5};
        vecs[25] = '{0, 0, 0, 64'h0,  1, 0, 1, 0, 64'h5};
        vecs[26] = '{0, 0, 1, 64'hE,  0, 1, 1, 1, 64'hE};
        vecs[27] = '{0, 0, 1, 64'hF,  0, 1, 0, 2, 64'hE};
        vecs[28] = '{1, 0, 0, 64'h0,  0, 0, 1, 0, RD};     // reset from FULL

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            check("out_valid", i, 64'(out_valid), 64'(vecs[i].e_ov));
            check("in_ready",  i, 64'(in_ready),  64'(vecs[i].e_ir));
            check("level",     i, 64'(level),     64'(vecs[i].e_lv));
            check("out_data",  i, out_data,       vecs[i].e_d);
        end

        // Random handshakes against a FIFO model of at most two entries.
        begin
            int accepted = 0;
            int cycles   = 0;
            int bad      = 0;
            bit acc, pop;
            while ((accepted < 1000 || q.size() != 0) && cycles < 20000) begin
                @(negedge clk);
                rst       = 1'b0;
                flush     = 1'b0;
                in_valid  = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data   = {$urandom, $urandom};
                out_ready = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (out_valid !== (q.size() != 0) || in_ready !== (q.size() != 2) ||
                    level !== 2'(q.size()) || (q.size() != 0 && out_data !== q[0])) begin
                    errors++;
                    bad++;
                    if (bad <= 5)
                        $display("FAIL random[%0d]: got v=%0b r=%0b lv=%0d d=%0h expected v=%0b r=%0b lv=%0d d=%0h",
                                 cycles, out_valid, in_ready, level, out_data, q.size() != 0,
                                 q.size() != 2, q.size(), (q.size() != 0) ? q[0] : 64'h0);
                end
                acc = in_valid && (q.size() != 2);
                pop = (q.size() != 0) && out_ready;
                if (pop) void'(q.pop_front());
                if (acc) begin
                    q.push_back(in_data);
                    accepted++;
                end
                cycles++;
            end
            checks++;
            if (accepted < 1000 || q.size() != 0) begin
                errors++;
                $display("FAIL random_timeout: got accepted=%0d pending=%0d expected 1000 and 0",
                         accepted, q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
